// File: rtl/module_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional macro DIVIDER_ZERO_CHECK_EN: detect divisor 0 at start and finish in one cycle.
module module_restoring_divider #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    input  logic [DIV_WIDTH-1:0] dividend_i,
    input  logic [DIV_WIDTH-1:0] divisor_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [DIV_WIDTH-1:0] quotient_o,
    output logic [DIV_WIDTH-1:0] remainder_o,
    output logic                 div_by_zero_o
);

    localparam int CW = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] divisor_q, divisor_d;
    logic [DIV_WIDTH-1:0] q_q, q_d;
    logic [DIV_WIDTH:0]   r_q, r_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] quot_q, quot_d;
    logic [DIV_WIDTH-1:0] rem_q, rem_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 dbz_q, dbz_d;

    logic [DIV_WIDTH:0]   r_shift_s;
    logic [DIV_WIDTH:0]   trial_s;
    logic                 borrow_s;
    logic [DIV_WIDTH:0]   r_next_s;
    logic [DIV_WIDTH-1:0] q_next_s;

    // Carry look-ahead adder: generate/propagate form, used here as a subtractor.
    function automatic logic [DIV_WIDTH:0] cla_add(
        input logic [DIV_WIDTH:0] a,
        input logic [DIV_WIDTH:0] b,
        input logic               cin
    );
        logic [DIV_WIDTH:0] g;
        logic [DIV_WIDTH:0] p;
        logic [DIV_WIDTH:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        for (int i = 0; i < DIV_WIDTH; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return p ^ c;
    endfunction

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        r_shift_s = {r_q[DIV_WIDTH-1:0], q_q[DIV_WIDTH-1]};
        trial_s   = cla_add(r_shift_s, ~{1'b0, divisor_q}, 1'b1);
        borrow_s  = trial_s[DIV_WIDTH];
        if (borrow_s) begin
            r_next_s = r_shift_s;
        end else begin
            r_next_s = trial_s;
        end
        q_next_s = {q_q[DIV_WIDTH-2:0], ~borrow_s};
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        divisor_d = divisor_q;
        q_d       = q_q;
        r_d       = r_q;
        cnt_d     = cnt_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    divisor_d = divisor_i;
                    q_d       = dividend_i;
                    r_d       = {(DIV_WIDTH+1){1'b0}};
                    cnt_d     = {CW{1'b0}};
                    dbz_d     = 1'b0;
`ifdef DIVIDER_ZERO_CHECK_EN
                    if (divisor_i == {DIV_WIDTH{1'b0}}) begin
                        quot_d  = {DIV_WIDTH{1'b1}};
                        rem_d   = dividend_i;
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
`else
                    state_d = ST_RUN;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                r_d   = r_next_s;
                q_d   = q_next_s;
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                // Last iteration publishes results directly on the DONE entry edge.
                if (cnt_q == CW'(DIV_WIDTH - 1)) begin
                    quot_d  = q_next_s;
                    rem_d   = r_next_s[DIV_WIDTH-1:0];
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            divisor_q <= {DIV_WIDTH{1'b0}};
            q_q       <= {DIV_WIDTH{1'b0}};
            r_q       <= {(DIV_WIDTH+1){1'b0}};
            cnt_q     <= {CW{1'b0}};
            quot_q    <= {DIV_WIDTH{1'b0}};
            rem_q     <= {DIV_WIDTH{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            divisor_q <= divisor_d;
            q_q       <= q_d;
            r_q       <= r_d;
            cnt_q     <= cnt_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign quotient_o  = quot_q;
    assign remainder_o = rem_q;
`ifdef DIVIDER_ZERO_CHECK_EN
    assign div_by_zero_o = dbz_q;
`else
    assign div_by_zero_o = 1'b0 & dbz_q;
`endif

endmodule

// File: tb/tb_module_restoring_divider.sv
// Self-checking bench for module_restoring_divider (DIV_WIDTH = 8): arithmetic
// reference model compared every cycle, plus directed literal expectations.
module tb_module_restoring_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n_i;
    logic         start_i;
    logic [W-1:0] dividend_i;
    logic [W-1:0] divisor_i;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] quotient_o;
    logic [W-1:0] remainder_o;
    logic         div_by_zero_o;

    int pass_cnt = 0;
    int check_cnt = 0;
    bit cmp_en = 1'b0;

    module_restoring_divider #(.DIV_WIDTH(W)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n_i),
        .start_i      (start_i),
        .dividend_i   (dividend_i),
        .divisor_i    (divisor_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .quotient_o   (quotient_o),
        .remainder_o  (remainder_o),
        .div_by_zero_o(div_by_zero_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain a/b and a%b, with a cycle countdown for the latency.
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_q = '0;
    logic [W-1:0] m_r = '0;
    logic         m_dbz = 1'b0;
    logic [W-1:0] p_q = '0;
    logic [W-1:0] p_r = '0;
    int           m_left = 0;

    always @(posedge clk) begin
        if (!rst_n_i) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_q <= '0; m_r <= '0; m_dbz <= 1'b0; m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0; m_done <= 1'b1; m_q <= p_q; m_r <= p_r;
                end
            end else if (start_i) begin
                p_q   <= (divisor_i == 0) ? 8'hFF : dividend_i / divisor_i;
                p_r   <= (divisor_i == 0) ? dividend_i : dividend_i % divisor_i;
                m_dbz <= 1'b0;
`ifdef DIVIDER_ZERO_CHECK_EN
                if (divisor_i == 0) begin
                    m_done <= 1'b1; m_q <= 8'hFF; m_r <= dividend_i; m_dbz <= 1'b1;
                end else begin
                    m_busy <= 1'b1; m_left <= W;
                end
`else
                m_busy <= 1'b1; m_left <= W;
`endif
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", 32'(busy_o), 32'(m_busy));
            chk("done", 32'(done_o), 32'(m_done));
            chk("quotient", 32'(quotient_o), 32'(m_q));
            chk("remainder", 32'(remainder_o), 32'(m_r));
            chk("div_by_zero", 32'(div_by_zero_o), 32'(m_dbz));
            chk("busy_and_done", 32'(busy_o & done_o), 32'd0);
        end
    end

    // Called at a negedge; drives start for exactly one rising edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        start_i = 1'b1; dividend_i = a; divisor_i = b;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Counts rising edges after the start edge until done_o is seen.
    task automatic wait_done(input string name, input int off0, input int exp_off);
        int off;
        off = off0;
        while (!done_o && off < 40) begin
            @(negedge clk);
            off++;
        end
        chk({name, "_latency"}, 32'(off), 32'(exp_off));
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int exp_q, input int exp_r, input int exp_off, input int exp_dbz);
        @(negedge clk);
        start_op(a, b);
        wait_done(name, 0, exp_off);
        chk({name, "_q"}, 32'(quotient_o), 32'(exp_q));
        chk({name, "_r"}, 32'(remainder_o), 32'(exp_r));
        chk({name, "_dbz"}, 32'(div_by_zero_o), 32'(exp_dbz));
    endtask

    initial begin
        rst_n_i = 1'b0; start_i = 1'b0; dividend_i = '0; divisor_i = '0;
        @(negedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        rst_n_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_done", 32'(done_o), 32'd0);
        chk("reset_q", 32'(quotient_o), 32'd0);
        chk("reset_r", 32'(remainder_o), 32'd0);
        chk("reset_dbz", 32'(div_by_zero_o), 32'd0);

        run_op("d100_7", 8'd100, 8'd7, 14, 2, 8, 0);
        run_op("d255_1", 8'd255, 8'd1, 255, 0, 8, 0);
        run_op("d5_9", 8'd5, 8'd9, 0, 5, 8, 0);
        run_op("d255_255", 8'd255, 8'd255, 1, 0, 8, 0);
`ifdef DIVIDER_ZERO_CHECK_EN
        run_op("d200_0", 8'd200, 8'd0, 255, 200, 0, 1);
`else
        run_op("d200_0", 8'd200, 8'd0, 255, 200, 8, 0);
`endif

        // Start pulse during busy is ignored; start in the DONE cycle is accepted.
        @(negedge clk);
        start_op(8'd100, 8'd7);
        repeat (2) @(negedge clk);
        start_op(8'd50, 8'd5);
        dividend_i = '0; divisor_i = '0;
        wait_done("ignored", 3, 8);
        chk("ignored_q", 32'(quotient_o), 32'd14);
        chk("ignored_r", 32'(remainder_o), 32'd2);
        start_op(8'd50, 8'd5);
        wait_done("b2b", 0, 8);
        chk("b2b_q", 32'(quotient_o), 32'd10);
        chk("b2b_r", 32'(remainder_o), 32'd0);

        // Reset in the middle of a division aborts it without a done pulse.
        @(negedge clk);
        start_op(8'd100, 8'd7);
        repeat (3) @(negedge clk);
        rst_n_i = 1'b0;
        @(negedge clk);
        rst_n_i = 1'b1;
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_q", 32'(quotient_o), 32'd0);
        chk("abort_r", 32'(remainder_o), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done_o), 32'd0);
        end
        run_op("d9_3", 8'd9, 8'd3, 3, 0, 8, 0);

        // Random non-zero divisors: algebraic identity plus the per-cycle model.
        for (int n = 0; n < 1000; n++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            @(negedge clk);
            start_op(a, b);
            wait_done("rand", 0, 8);
            chk("rand_identity", 32'(quotient_o) * 32'(b) + 32'(remainder_o), 32'(a));
            chk("rand_rem_lt_div", 32'(remainder_o < b), 32'd1);
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
